// File: rtl/para_sram_pkg.sv
// Shared constants and address-split helpers for the banked parallel SRAM.
// Default geometry: 6 ports, 8 banks, 13-bit word address, 24-bit words.
// Low-order address bits pick the bank; the remaining upper bits pick the row.
package para_sram_pkg;

    localparam int unsigned NUM_PORTS_DEF = 6;
    localparam int unsigned NUM_BANKS_DEF = 8;
    localparam int unsigned ADDR_W_DEF    = 13;
    localparam int unsigned DATA_W_DEF    = 24;

    localparam int unsigned BANK_W = $clog2(NUM_BANKS_DEF);
    localparam int unsigned ROW_W  = ADDR_W_DEF - BANK_W;

    // Bank index: the low bank_w bits of the word address.
    function automatic int unsigned bank_of(input logic [31:0] addr, input int unsigned bank_w);
        return 32'(addr & ((32'd1 << bank_w) - 32'd1));
    endfunction

    // Row index inside a bank: the address with the bank bits stripped.
    function automatic int unsigned row_of(input logic [31:0] addr, input int unsigned bank_w);
        return 32'(addr >> bank_w);
    endfunction

endpackage

// File: rtl/para_sram_rr_arbiter.sv
// Round-robin arbiter for one bank.
//   i_clk, i_rst_n : clock, synchronous active-low reset (pointer -> 0)
//   i_req[N]       : candidate ports targeting this bank
//   o_grant[N]     : combinational one-hot grant (all zero with no candidates)
// The grant goes to the first requester at or after the pointer, scanning
// cyclically; the pointer then moves one past the winner.
module rr_arbiter #(
    parameter int unsigned N = 6
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_grant
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Cyclic priority scan starting at the pointer.
    always_comb begin
        int unsigned      pos;
        logic [PTR_W-1:0] idx;
        logic             found;
        o_grant = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        pos     = 0;
        idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = 32'(ptr_q) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            idx = PTR_W'(pos);
            if (!found && i_req[idx]) begin
                found        = 1'b1;
                o_grant[idx] = 1'b1;
                ptr_d        = (pos == N - 1) ? '0 : PTR_W'(pos + 1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/para_sram_banked.sv
// Multi-port word store built from single-port banks with low-order
// address interleaving and per-bank round-robin arbitration.
//   i_clk, i_rst_n    : clock, synchronous active-low reset
//   i_req/i_we        : per-port request and write enable
//   i_address         : per-port word address
//   i_write_data      : per-port write data
//   o_ready           : combinational grant (request accepted this cycle)
//   o_rvalid          : one-cycle pulse, read data for last cycle's accepted read
//   o_read_data       : per-port read data, held while o_rvalid is low
module para_sram_banked
    import para_sram_pkg::*;
#(
    parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
    parameter int unsigned NUM_BANKS = NUM_BANKS_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [NUM_PORTS-1:0]              i_req,
    input  logic [NUM_PORTS-1:0]              i_we,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  i_address,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]  i_write_data,
    output logic [NUM_PORTS-1:0]              o_ready,
    output logic [NUM_PORTS-1:0]              o_rvalid,
    output logic [NUM_PORTS-1:0][DATA_W-1:0]  o_read_data
);

    localparam int unsigned BANK_IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned ROW_IDX_W  = ADDR_W - BANK_IDX_W;
    localparam int unsigned DEPTH      = 1 << ROW_IDX_W;

    if (NUM_BANKS < 2 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_cfg_err
        $error("para_sram_banked: NUM_BANKS must be a power of 2 and >= 2");
    end

    logic [BANK_IDX_W-1:0] port_bank   [NUM_PORTS];
    logic [ROW_IDX_W-1:0]  port_row    [NUM_PORTS];
    logic [NUM_PORTS-1:0]  bank_req    [NUM_BANKS];
    logic [NUM_PORTS-1:0]  bank_grant  [NUM_BANKS];
    logic [DATA_W-1:0]     bank_rdata  [NUM_BANKS];

    logic [NUM_PORTS-1:0]             rvalid_q;
    logic [BANK_IDX_W-1:0]            rbank_q [NUM_PORTS];
    logic [NUM_PORTS-1:0][DATA_W-1:0] hold_q;

    // Split each port address into bank and row.
    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            port_bank[p] = BANK_IDX_W'(bank_of(32'(i_address[p]), BANK_IDX_W));
            port_row[p]  = ROW_IDX_W'(row_of(32'(i_address[p]), BANK_IDX_W));
        end
    end

    // Route requests to their target bank.
    always_comb begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                bank_req[b][p] = i_req[p] && (port_bank[p] == BANK_IDX_W'(b));
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic                 en_c;
        logic                 we_c;
        logic [ROW_IDX_W-1:0] row_c;
        logic [DATA_W-1:0]    wdata_c;
        logic [DATA_W-1:0]    mem [DEPTH];
        logic [DATA_W-1:0]    rdata_q;

        rr_arbiter #(
            .N (NUM_PORTS)
        ) u_arb (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_req   (bank_req[b]),
            .o_grant (bank_grant[b])
        );

        // Mux the single granted port onto the bank.
        always_comb begin
            en_c    = 1'b0;
            we_c    = 1'b0;
            row_c   = '0;
            wdata_c = '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (bank_grant[b][p]) begin
                    en_c    = 1'b1;
                    we_c    = i_we[p];
                    row_c   = port_row[p];
                    wdata_c = i_write_data[p];
                end
            end
        end

        // Single-port bank; accesses during reset are dropped.
        always_ff @(posedge i_clk) begin
            if (i_rst_n && en_c) begin
                if (we_c) begin
                    mem[row_c] <= wdata_c;
                end else begin
                    rdata_q <= mem[row_c];
                end
            end
        end

        assign bank_rdata[b] = rdata_q;
    end

    // A port is ready when its bank granted it.
    always_comb begin
        o_ready = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            o_ready = o_ready | bank_grant[b];
        end
    end

    // Read-return pipeline: remember which bank each accepted read used.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rvalid_q <= '0;
            hold_q   <= '0;
        end else begin
            rvalid_q <= o_ready & ~i_we;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (rvalid_q[p]) begin
                    hold_q[p] <= bank_rdata[rbank_q[p]];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            rbank_q[p] <= port_bank[p];
        end
    end

    // Fresh bank data on the valid cycle, otherwise the last returned word.
    always_comb begin
        o_rvalid = rvalid_q;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            o_read_data[p] = rvalid_q[p] ? bank_rdata[rbank_q[p]] : hold_q[p];
        end
    end

endmodule

// File: tb/tb_para_sram_banked.sv
// Randomized and directed bench for para_sram_banked against a behavioural
// model: a flat word array, one round-robin pointer per bank, and expected
// per-port read returns.
module tb_para_sram_banked;

    localparam int NP = 6;
    localparam int NB = 8;
    localparam int AW = 13;
    localparam int DW = 24;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NP-1:0]            req;
    logic [NP-1:0]            we;
    logic [NP-1:0][AW-1:0]    addr;
    logic [NP-1:0][DW-1:0]    wdata;
    logic [NP-1:0]            ready;
    logic [NP-1:0]            rvalid;
    logic [NP-1:0][DW-1:0]    rdata;

    para_sram_banked #(
        .NUM_PORTS (NP),
        .NUM_BANKS (NB),
        .ADDR_W    (AW),
        .DATA_W    (DW)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req        (req),
        .i_we         (we),
        .i_address    (addr),
        .i_write_data (wdata),
        .o_ready      (ready),
        .o_rvalid     (rvalid),
        .o_read_data  (rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model state.
    logic [DW-1:0] m_mem   [1 << AW];
    bit            m_known [1 << AW];
    int            m_ptr   [NB];
    bit [NP-1:0]   exp_rv;
    logic [DW-1:0] exp_rd  [NP];
    bit            exp_rd_known [NP];
    bit            ptr_known = 0;
    bit            out_known = 0;
    logic [NP-1:0] obs_ready;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check outputs against the model, then advance the model.
    task automatic cycle();
        logic [NP-1:0] g;
        int            p;
        @(negedge clk);
        g = '0;
        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < NP; i++) begin
                p = (m_ptr[b] + i) % NP;
                if (req[p] && (int'(addr[p]) % NB) == b) begin
                    g[p] = 1'b1;
                    break;
                end
            end
        end
        obs_ready = ready;
        if (ptr_known) chk("ready", 32'(ready), 32'(g));
        if (out_known) begin
            for (int q = 0; q < NP; q++) begin
                chk($sformatf("rvalid[%0d]", q), 32'(rvalid[q]), 32'(exp_rv[q]));
                if (exp_rd_known[q]) chk($sformatf("rdata[%0d]", q), 32'(rdata[q]), 32'(exp_rd[q]));
            end
        end
        if (!rst_n) begin
            for (int b = 0; b < NB; b++) m_ptr[b] = 0;
            exp_rv = '0;
            for (int q = 0; q < NP; q++) begin
                exp_rd[q] = '0;
                exp_rd_known[q] = 1;
            end
            ptr_known = 1;
            out_known = 1;
        end else begin
            exp_rv = '0;
            for (int q = 0; q < NP; q++) begin
                if (g[q]) m_ptr[int'(addr[q]) % NB] = (q + 1) % NP;
                if (g[q] && !we[q]) begin
                    exp_rv[q]       = 1'b1;
                    exp_rd[q]       = m_mem[addr[q]];
                    exp_rd_known[q] = m_known[addr[q]];
                end
            end
            for (int q = 0; q < NP; q++) begin
                if (g[q] && we[q]) begin
                    m_mem[addr[q]]   = wdata[q];
                    m_known[addr[q]] = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input bit w, input int a, input int d);
        req[p]   = 1'b1;
        we[p]    = w;
        addr[p]  = AW'(a);
        wdata[p] = DW'(d);
    endtask

    int rv_cnt [NP];

    initial begin
        rst_n = 1'b0;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        for (int i = 0; i < (1 << AW); i++) m_known[i] = 0;
        for (int b = 0; b < NB; b++) m_ptr[b] = 0;
        for (int q = 0; q < NP; q++) exp_rd_known[q] = 0;
        exp_rv = '0;
        #1;

        // Reset held two cycles with random traffic.
        for (int c = 0; c < 2; c++) begin
            for (int q = 0; q < NP; q++) set_port(q, 1'($urandom), $urandom_range(0, 63), $urandom);
            req = NP'($urandom);
            cycle();
        end
        rst_n = 1'b1;
        req   = '0;
        cycle();
        chk("rst_release_rvalid", 32'(rvalid), 32'h0);

        // Two writers on bank 0 straight out of reset.
        set_port(0, 1, 56, 100);
        set_port(1, 1, 0, 0);
        cycle();
        chk("conf_w0", 32'(obs_ready), 32'h01);
        req[0] = 1'b0;
        cycle();
        chk("conf_w1", 32'(obs_ready), 32'h02);
        set_port(0, 0, 56, 0);
        set_port(1, 0, 0, 0);
        cycle();
        chk("conf_r0", 32'(obs_ready), 32'h01);
        chk("conf_r0_data", 32'(rdata[0]), 32'd100);
        req[0] = 1'b0;
        cycle();
        chk("conf_r1", 32'(obs_ready), 32'h02);
        chk("conf_r1_data", 32'(rdata[1]), 32'd0);
        req = '0;

        // Three writes then three reads on distinct banks.
        set_port(0, 1, 41, 50);
        set_port(1, 1, 10, 1000);
        set_port(2, 1, 3, 7);
        cycle();
        chk("par_w", 32'(obs_ready), 32'h07);
        req = '0;
        set_port(3, 0, 41, 0);
        set_port(4, 0, 10, 0);
        set_port(5, 0, 3, 0);
        cycle();
        chk("par_r", 32'(obs_ready), 32'h38);
        chk("par_rvalid", 32'(rvalid), 32'h38);
        chk("par_d3", 32'(rdata[3]), 32'd50);
        chk("par_d4", 32'(rdata[4]), 32'd1000);
        chk("par_d5", 32'(rdata[5]), 32'd7);
        req = '0;

        // Write then read of the same address on consecutive cycles.
        set_port(0, 1, 41, 40);
        cycle();
        req = '0;
        set_port(2, 0, 41, 0);
        cycle();
        chk("wr_rd_data", 32'(rdata[2]), 32'd40);
        req = '0;
        set_port(0, 1, 41, 50);
        cycle();
        req = '0;
        // Read wins against a concurrent write to the same word.
        set_port(2, 0, 41, 0);
        set_port(3, 1, 41, 77);
        cycle();
        chk("rd_vs_w_grant", 32'(obs_ready), 32'h04);
        chk("rd_vs_w_old", 32'(rdata[2]), 32'd50);
        req[2] = 1'b0;
        cycle();
        chk("late_write", 32'(obs_ready), 32'h08);
        req = '0;

        // All ports hammer bank 5: grants must rotate.
        for (int q = 0; q < NP; q++) begin
            set_port(q, 0, 5 + 8 * q, 0);
            rv_cnt[q] = 0;
        end
        for (int c = 0; c < 12; c++) begin
            cycle();
            chk($sformatf("rr_grant%0d", c), 32'(obs_ready), 32'(1 << (c % NP)));
            for (int q = 0; q < NP; q++) if (rvalid[q]) rv_cnt[q]++;
        end
        for (int q = 0; q < NP; q++) chk($sformatf("rr_pulses%0d", q), 32'(rv_cnt[q]), 32'd2);
        req = '0;

        // Reset lands on an accepted read and an accepted write.
        rst_n = 1'b0;
        set_port(0, 0, 41, 0);
        set_port(1, 1, 10, 999);
        cycle();
        chk("midrst_rvalid", 32'(rvalid), 32'h0);
        rst_n = 1'b1;
        set_port(0, 0, 10, 0);
        set_port(1, 0, 41, 0);
        cycle();
        chk("midrst_keep10", 32'(rdata[0]), 32'd1000);
        chk("midrst_keep41", 32'(rdata[1]), 32'd77);
        req = '0;

        // Random traffic; losers hold their request until accepted.
        for (int c = 0; c < 400; c++) begin
            for (int q = 0; q < NP; q++) begin
                if (!req[q] || obs_ready[q] || !rst_n) begin
                    req[q]   = ($urandom_range(0, 3) != 0);
                    we[q]    = 1'($urandom);
                    addr[q]  = AW'($urandom_range(0, 63));
                    wdata[q] = DW'($urandom);
                end
            end
            rst_n = ($urandom_range(0, 49) != 0);
            cycle();
        end
        rst_n = 1'b1;
        req   = '0;
        cycle();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/para_sram_banked.md
Name: para_sram_banked

Overview:
- Generalised successor to the fixed 6-port parallel SRAM.
- NUM_PORTS independent request ports share NUM_BANKS single-port banks, with low-order address interleaving across banks.
- Per-bank round-robin arbitration resolves bank conflicts. Losing ports are back-pressured with o_ready low and hold their request.
- Adds per-port write enable, request/ready handshake and read-valid tagging; used as the shared pixel/coefficient store feeding the parallel datapath.

Parameters:
NUM_PORTS, 6, number of request ports
NUM_BANKS, 8, number of banks; power of 2, >=2
ADDR_W, 13, word address width; bank depth = 2**ADDR_W / NUM_BANKS
DATA_W, 24, word width

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  synchronous active-low reset
i_req  in  [NUM_PORTS]x1  port p requests an access this cycle
i_we  in  [NUM_PORTS]x1  1 = write, 0 = read; qualified by i_req
i_address  in  [NUM_PORTS]xADDR_W  word address
i_write_data  in  [NUM_PORTS]xDATA_W  write data
o_ready  out  [NUM_PORTS]x1  request accepted this cycle (combinational grant)
o_rvalid  out  [NUM_PORTS]x1  o_read_data valid for a read accepted last cycle
o_read_data  out  [NUM_PORTS]xDATA_W  read data

Behaviour:
- Clocking and reset: one clock i_clk; reset i_rst_n is synchronous, active-low.
- Reset values: o_rvalid all 0, o_read_data all 0, every bank round-robin pointer 0. Bank contents are not cleared.
- Reset mid-operation: a read accepted in the reset cycle produces no o_rvalid. A write accepted in the reset cycle is discarded.
- Address map: bank = i_address[log2(NUM_BANKS)-1:0], row = remaining upper bits.
- Arbitration, per bank b each cycle:
  - Candidates are ports with i_req=1 targeting bank b.
  - Grant goes to the first candidate at index >= ptr[b], scanning cyclically.
  - On a grant, ptr[b] <= granted+1 mod NUM_PORTS. With no candidates, ptr[b] holds.
- Handshake:
  - o_ready[p] = 1 iff p is granted; it is combinational from i_req/i_address/ptr and never depends on o_rvalid.
  - A port with o_ready=0 must hold i_req, i_we, i_address and i_write_data stable until accepted; holding is not checked.
  - o_ready with i_req=0 is always 0.
- Write: on acceptance, bank[row] <= i_write_data at that rising edge.
- Read latency 1:
  - Accepted in cycle N → o_rvalid[p]=1 and o_read_data[p]=bank[row] in cycle N+1. o_rvalid is a single-cycle pulse.
  - o_read_data holds its last value while o_rvalid=0.
- Same-bank read/write ordering is by grant order only:
  - A read granted in the cycle after a write to the same address returns the new data.
  - Two ports never access one bank in the same cycle.
- Distinct banks: all NUM_PORTS ports may be accepted in the same cycle; throughput is one access per bank per cycle.
- Fairness: under persistent contention, each requester to a bank is granted within NUM_PORTS cycles.
- Out-of-range configuration (NUM_BANKS not a power of 2): elaboration error via $error.

Decomposition:
- Package para_sram_pkg: BANK_W = $clog2(NUM_BANKS), ROW_W = ADDR_W - BANK_W, and functions bank_of(addr) and row_of(addr).
- Sub-module rr_arbiter (parameter N):
  - inputs i_clk, i_rst_n, i_req[N]; output o_grant[N] (one-hot or zero);
  - holds its own pointer; instantiated once per bank.
- Top level: request-to-bank routing, NUM_BANKS inferred RAM arrays, 1-cycle read-return pipeline (rvalid plus bank index per port).

Test Plan:
- Reset: hold i_rst_n=0 for 2 cycles with random i_req → o_rvalid=0 and o_read_data=0 throughout, and o_rvalid=0 in the first cycle after release.
- Parallel, no conflict:
  - write (41,50), (10,1000), (3,7) on ports 0/1/2 (banks 1,2,3) → all o_ready=1 in one cycle;
  - next cycle read 41, 10, 3 on ports 3/4/5 → o_rvalid=1 a cycle later with 50, 1000, 7.
- Bank conflict:
  - ports 0 and 1 write 56 and 0 (both bank 0) from reset → port 0 accepted in cycle 0, port 1 in cycle 1;
  - reading 56 and 0 returns 100 and 0 when port 0 writes 100 and port 1 writes 0.
- Write-then-read:
  - port 0 writes 41←40, then port 2 reads 41 the following cycle → 40 returned;
  - read of 41 issued in the same cycle as a losing write on another port → old value 50.
- Round-robin fairness: all 6 ports continuously read addresses in bank 5 for 12 cycles → grants rotate 0,1,2,3,4,5,0,…; each port receives exactly 2 o_rvalid pulses.
- Reset mid-operation: assert i_rst_n=0 in the cycle a read of 41 is accepted → no o_rvalid the next cycle; a write accepted in the same cycle leaves the old contents.
